fft_frame_loader: RTL
=====================

// Module: fft_frame_loader
// PURPOSE
//  Sits between i2s and fft. Captures left-channel samples as i2s completes them,
//  packs them into 2**N_2-sample frames in a ping-pong buffer, then starts the fft
//  and streams one frame into its load/rd port while the next frame fills.
//  Frames that complete while the fft or stream is busy are dropped and counted.
// PARAMETERS
//  WIDTH  16  fft sample width; sample kept = left[23 -: WIDTH] (MSBs, no rounding)
//  N_2    5   log2 frame length; frame = 2**N_2 samples
//  DECIM  1   keep every DECIM-th sample (1 = keep all); legal range 1..255
// PORTS
//  clk            in   1        system clock (same domain as i2s and fft)
//  reset          in   1        asynchronous, active-high reset
//  lrck           in   1        i2s word clock; rising edge = new left sample valid
//  left           in   24       i2s left sample, two's complement
//  fft_done       in   1        fft output phase active; falling edge = fft idle
//  start          out  1        one-cycle pulse, fft begins a transform
//  load           out  1        high for exactly 2**N_2 consecutive cycles per frame
//  rd             out  WIDTH    frame sample, valid whenever load=1, else 0
//  frame_dropped  out  1        one-cycle pulse when a filled frame is discarded
//  drop_count     out  8        frames dropped since reset, saturates at 255
// BEHAVIOUR
//  Reset: all outputs 0; write bank 0, write index 0, decim count 0, FSM IDLE,
//   fft_busy 0. Asserting reset mid-frame/mid-stream aborts both immediately.
//  Capture: lrck registered once; strobe = lrck_q & ~lrck_q2 (1 cycle). On strobe,
//   decim counter advances modulo DECIM; sample written only when counter==0, to
//   buf[wbank][widx], widx++.
//  Frame full: write of widx==2**N_2-1. If FSM==IDLE and fft_busy==0: same edge
//   swap (rbank<=wbank, wbank<=~wbank), widx wraps to 0, FSM->START. Otherwise frame
//   dropped: bank not swapped, widx wraps to 0 (bank overwritten), frame_dropped=1
//   next cycle, drop_count++ (saturating).
//  fft_busy: set when start pulses; cleared on fft_done falling edge (registered).
//  FSM: IDLE -> START (start=1 one cycle, ridx<=0) -> LOAD (load=1, rd=buf[rbank][ridx],
//   ridx++ per cycle; after ridx==2**N_2-1 -> IDLE). load rises cycle after start.
//   Total: start at T, load T+1..T+2**N_2, rd registered and aligned with load.
//  Simultaneous strobe in LOAD: write bank != read bank, both proceed; no stall.
//  Strobe coinciding with reset deassert edge ignored (capture regs still cleared).
//  Stream never pauses; fft must accept 1 sample/cycle during load.
//  Samples between frames are never lost unless a whole frame is dropped.
//  Buffer: 2*2**N_2 x WIDTH, write port and read port independent (one each).
// TESTING
//  1 Reset: hold reset, toggle lrck -> start/load/rd/frame_dropped/drop_count all 0.
//  2 Frame: 32 lrck edges, left={i[15:0],8'h00}, i=0..31 -> one start, then load 32
//    cycles with rd=0..31 in order; load low otherwise.
//  3 Overlap: keep fft_done low (busy) after frame 1, send 32 more -> frame_dropped
//    pulse, drop_count=1, no start; drive fft_done 1->0, next 32 samples start.
//  4 Ping-pong: continuous lrck every 40 clk, fft_done pulse after each load ->
//    frames k,k+1 streamed intact, no drops, rd shows no mixing of frames.
//  5 DECIM=4: 128 edges, left=edge index<<8 -> rd=0,4,8..124.
//  6 Reset mid-LOAD (ridx=10) -> load drops same clk edge; next frame starts ridx=0.

Source files
------------

// File: rtl/fft_frame_loader_if.sv
// rtl/fft_frame_loader_if.sv - i2s capture inputs and fft load/stream outputs of the frame loader
interface fft_frame_loader_if #(
    parameter int WIDTH = 16
);
    logic             lrck;
    logic [23:0]      left;
    logic             fft_done;
    logic             start;
    logic             load;
    logic [WIDTH-1:0] rd;
    logic             frame_dropped;
    logic [7:0]       drop_count;

    modport master (
        output lrck, left, fft_done,
        input  start, load, rd, frame_dropped, drop_count
    );

    modport slave (
        input  lrck, left, fft_done,
        output start, load, rd, frame_dropped, drop_count
    );
endinterface

// File: rtl/fft_frame_loader.sv
// rtl/fft_frame_loader.sv - ping-pong frame buffer from i2s left samples to the fft load port
// A frame fills one bank while the other streams; full frames arriving while busy are dropped.
module fft_frame_loader #(
    parameter int WIDTH = 16,
    parameter int N_2   = 5,
    parameter int DECIM = 1
) (
    input  logic              clk,
    input  logic              reset,
    fft_frame_loader_if.slave io
);
    localparam int FRAME = 1 << N_2;

    typedef enum logic [1:0] {S_IDLE, S_START, S_LOAD} state_t;

    state_t           state_q, state_d;
    logic             lrck_q, lrck_q2, done_q;
    logic [7:0]       dcnt_q, dcnt_d;
    logic [N_2-1:0]   widx_q, widx_d;
    logic [N_2-1:0]   ridx_q, ridx_d;
    logic             wbank_q, wbank_d;
    logic             rbank_q, rbank_d;
    logic             busy_q, busy_d;
    logic             start_q, start_d;
    logic             load_q, load_d;
    logic             drop_q, drop_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic [7:0]       drop_count_q, drop_count_d;
    logic [WIDTH-1:0] mem [2*FRAME];

    logic strobe, wr_en, frame_full, accept, done_fall;
    logic [23-WIDTH:0] unused_left;

    assign unused_left = io.left[23-WIDTH:0];
    assign strobe      = lrck_q & ~lrck_q2;
    assign wr_en       = strobe && (dcnt_q == 8'(0));
    assign frame_full  = wr_en && (widx_q == '1);
    assign accept      = frame_full && (state_q == S_IDLE) && !busy_q;
    assign done_fall   = done_q & ~io.fft_done;

    always_comb begin
        state_d      = state_q;
        dcnt_d       = dcnt_q;
        widx_d       = widx_q;
        ridx_d       = ridx_q;
        wbank_d      = wbank_q;
        rbank_d      = rbank_q;
        busy_d       = busy_q;
        drop_count_d = drop_count_q;
        start_d      = 1'b0;
        load_d       = 1'b0;
        drop_d       = 1'b0;
        rd_d         = '0;

        if (strobe) begin
            dcnt_d = (dcnt_q == 8'(DECIM - 1)) ? 8'(0) : dcnt_q + 8'(1);
        end
        if (wr_en) begin
            widx_d = widx_q + 1'b1;
        end
        // A dropped frame keeps its bank, so the next frame simply overwrites it.
        if (accept) begin
            wbank_d = ~wbank_q;
            rbank_d = wbank_q;
        end else if (frame_full) begin
            drop_d = 1'b1;
            if (drop_count_q != 8'hff) begin
                drop_count_d = drop_count_q + 8'(1);
            end
        end

        if (start_q) begin
            busy_d = 1'b1;
        end else if (done_fall) begin
            busy_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_START;
                    start_d = 1'b1;
                    ridx_d  = '0;
                end
            end
            S_START: begin
                state_d = S_LOAD;
                load_d  = 1'b1;
                rd_d    = mem[{rbank_q, ridx_q}];
                ridx_d  = ridx_q + 1'b1;
            end
            S_LOAD: begin
                // ridx wraps to zero once the last sample has been issued
                if (ridx_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    load_d = 1'b1;
                    rd_d   = mem[{rbank_q, ridx_q}];
                    ridx_d = ridx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lrck_q       <= 1'b0;
            lrck_q2      <= 1'b0;
            done_q       <= 1'b0;
            dcnt_q       <= '0;
            widx_q       <= '0;
            ridx_q       <= '0;
            wbank_q      <= 1'b0;
            rbank_q      <= 1'b0;
            busy_q       <= 1'b0;
            start_q      <= 1'b0;
            load_q       <= 1'b0;
            drop_q       <= 1'b0;
            rd_q         <= '0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            lrck_q       <= io.lrck;
            lrck_q2      <= lrck_q;
            done_q       <= io.fft_done;
            dcnt_q       <= dcnt_d;
            widx_q       <= widx_d;
            ridx_q       <= ridx_d;
            wbank_q      <= wbank_d;
            rbank_q      <= rbank_d;
            busy_q       <= busy_d;
            start_q      <= start_d;
            load_q       <= load_d;
            drop_q       <= drop_d;
            rd_q         <= rd_d;
            drop_count_q <= drop_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wbank_q, widx_q}] <= io.left[23 -: WIDTH];
        end
    end

    assign io.start         = start_q;
    assign io.load          = load_q;
    assign io.rd            = rd_q;
    assign io.frame_dropped = drop_q;
    assign io.drop_count    = drop_count_q;
endmodule
